// File: rtl/servo_slew_ctrl.sv
// -----------------------------------------------------------------------------
// servo_slew_ctrl
//
// Command stage in front of the servo PWM generator. Target pulse widths come
// in over a valid/ready handshake, are clamped into the safe servo window, and
// duty_out ramps toward the target by at most STEP counts per PWM frame.
// duty_out only changes on the edge that closes a frame_tick cycle, so the
// PWM generator never sees a width change in the middle of a period.
//
// Ports
//   clk         system clock (50 kHz)
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_duty    requested duty count (unsigned, 10 bits)
//   cmd_ready   block can accept a command (registered, low in reset)
//   duty_out    duty count to the PWM generator (registered)
//   moving      high while duty_out differs from the target
//   arrived     one-cycle pulse after a move completes
//   clamped     one-cycle pulse after an out-of-range command was accepted
//   frame_tick  one-cycle pulse on the last clock of each frame
// -----------------------------------------------------------------------------
module servo_slew_ctrl #(
    parameter int FRAME_TICKS = 1000,
    parameter int MIN_DUTY    = 50,
    parameter int MAX_DUTY    = 100,
    parameter int INIT_DUTY   = 75,
    parameter int STEP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_duty,
    output logic       cmd_ready,
    output logic [9:0] duty_out,
    output logic       moving,
    output logic       arrived,
    output logic       clamped,
    output logic       frame_tick
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    localparam logic [9:0]  MIN_D     = 10'(MIN_DUTY);
    localparam logic [9:0]  MAX_D     = 10'(MAX_DUTY);
    localparam logic [9:0]  INIT_D    = 10'(INIT_DUTY);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    // 10 bits cover every legal frame length up to 1024 clocks.
    localparam logic [9:0]  FCNT_LAST = 10'(FRAME_TICKS - 1);

    // Clamp a requested duty into [MIN_D, MAX_D].
    function automatic logic [9:0] clamp_duty(input logic [9:0] d);
        logic [9:0] r;
        if (d < MIN_D) begin
            r = MIN_D;
        end else if (d > MAX_D) begin
            r = MAX_D;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // True when a requested duty lies outside the safe window.
    function automatic logic out_of_range(input logic [9:0] d);
        return (d < MIN_D) || (d > MAX_D);
    endfunction

    logic [9:0]  fcnt_r;
    state_t      state_r;
    state_t      state_nxt_s;
    logic [9:0]  target_r;
    logic [9:0]  target_nxt_s;
    logic [9:0]  duty_r;
    logic [9:0]  duty_nxt_s;
    logic [9:0]  stepped_s;
    logic [10:0] diff_up_s;
    logic [10:0] diff_dn_s;
    logic [10:0] step_amt_s;
    logic        arrived_r;
    logic        arrived_nxt_s;
    logic        clamped_r;
    logic        clamped_nxt_s;
    logic        cmd_ready_r;
    logic        accept_s;
    logic        frame_tick_s;

    // Frame counter: 0 .. FRAME_TICKS-1, then wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r <= 10'd0;
        end else if (fcnt_r == FCNT_LAST) begin
            fcnt_r <= 10'd0;
        end else begin
            fcnt_r <= fcnt_r + 10'd1;
        end
    end

    assign frame_tick_s = (fcnt_r == FCNT_LAST);
    assign accept_s     = cmd_valid && cmd_ready_r;

    // One frame's worth of slew toward the current (old) target; the
    // differences are 11 bits wide so neither direction can wrap.
    always_comb begin
        diff_up_s  = {1'b0, target_r} - {1'b0, duty_r};
        diff_dn_s  = {1'b0, duty_r} - {1'b0, target_r};
        step_amt_s = 11'd0;
        stepped_s  = duty_r;
        if (duty_r < target_r) begin
            step_amt_s = (diff_up_s < STEP_W) ? diff_up_s : STEP_W;
            stepped_s  = duty_r + step_amt_s[9:0];
        end else if (duty_r > target_r) begin
            step_amt_s = (diff_dn_s < STEP_W) ? diff_dn_s : STEP_W;
            stepped_s  = duty_r - step_amt_s[9:0];
        end else begin
            step_amt_s = 11'd0;
            stepped_s  = duty_r;
        end
    end

    // Next-state, target, duty and pulse decode.
    always_comb begin
        state_nxt_s   = state_r;
        target_nxt_s  = target_r;
        duty_nxt_s    = duty_r;
        arrived_nxt_s = 1'b0;
        clamped_nxt_s = 1'b0;

        if ((state_r == ST_MOVING) && frame_tick_s) begin
            duty_nxt_s = stepped_s;
        end else begin
            duty_nxt_s = duty_r;
        end

        if (accept_s) begin
            target_nxt_s  = clamp_duty(cmd_duty);
            clamped_nxt_s = out_of_range(cmd_duty);
        end else begin
            target_nxt_s  = target_r;
            clamped_nxt_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                // An accepted target equal to duty_out leaves us idle silently.
                if (accept_s && (target_nxt_s != duty_r)) begin
                    state_nxt_s = ST_MOVING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MOVING: begin
                // Compare against the post-step duty so a retarget landing on
                // the value reached this edge still completes the move.
                if (duty_nxt_s == target_nxt_s) begin
                    state_nxt_s   = ST_IDLE;
                    arrived_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_MOVING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            target_r    <= INIT_D;
            duty_r      <= INIT_D;
            arrived_r   <= 1'b0;
            clamped_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            target_r    <= target_nxt_s;
            duty_r      <= duty_nxt_s;
            arrived_r   <= arrived_nxt_s;
            clamped_r   <= clamped_nxt_s;
            cmd_ready_r <= 1'b1;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign duty_out   = duty_r;
    assign moving     = (state_r == ST_MOVING);
    assign arrived    = arrived_r;
    assign clamped    = clamped_r;
    assign frame_tick = frame_tick_s;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for servo_slew_ctrl with FRAME_TICKS = 10. Instance 0 uses
// STEP = 1, instance 1 uses STEP = 4; each has its own reset and command port.
// -----------------------------------------------------------------------------
module tb_servo_slew_ctrl;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] cmd_valid;
    logic [9:0] cmd_duty [2];
    logic [1:0] cmd_ready;
    logic [9:0] duty_out [2];
    logic [1:0] moving;
    logic [1:0] arrived;
    logic [1:0] clamped;
    logic [1:0] frame_tick;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    servo_slew_ctrl #(
        .FRAME_TICKS(10), .MIN_DUTY(50), .MAX_DUTY(100), .INIT_DUTY(75), .STEP(1)
    ) u_step1 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_duty(cmd_duty[0]),
        .cmd_ready(cmd_ready[0]), .duty_out(duty_out[0]), .moving(moving[0]),
        .arrived(arrived[0]), .clamped(clamped[0]), .frame_tick(frame_tick[0])
    );

    servo_slew_ctrl #(
        .FRAME_TICKS(10), .MIN_DUTY(50), .MAX_DUTY(100), .INIT_DUTY(75), .STEP(4)
    ) u_step4 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_duty(cmd_duty[1]),
        .cmd_ready(cmd_ready[1]), .duty_out(duty_out[1]), .moving(moving[1]),
        .arrived(arrived[1]), .clamped(clamped[1]), .frame_tick(frame_tick[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_tick is high (bounded), without crossing that edge.
    task automatic find_ft(input int d);
        int n;
        n = 0;
        while ((frame_tick[d] !== 1'b1) && (n < 25)) begin
            cyc();
            n++;
        end
        if (n >= 25) chk("tick_timeout", 32'(frame_tick[d]), 32'd1);
    endtask

    // Cross the next frame_tick edge.
    task automatic pass_ft(input int d);
        find_ft(d);
        cyc();
    endtask

    task automatic do_reset(input int d);
        rst[d]       = 1'b1;
        cmd_valid[d] = 1'b0;
        repeat (3) cyc();
        rst[d] = 1'b0;
        cyc();
    endtask

    // Present one command on a non-tick cycle for exactly one edge.
    task automatic send(input int d, input logic [9:0] v);
        if (frame_tick[d] === 1'b1) cyc();
        cmd_valid[d] = 1'b1;
        cmd_duty[d]  = v;
        cyc();
        cmd_valid[d] = 1'b0;
    endtask

    // Cross one tick and check the new duty plus arrival status.
    task automatic tick_chk(input int d, input int exp, input bit last, input string tag);
        pass_ft(d);
        chk(tag, 32'(duty_out[d]), 32'(exp));
        chk({tag, "_arrived"}, 32'(arrived[d]), 32'(last));
        chk({tag, "_moving"}, 32'(moving[d]), 32'(!last));
    endtask

    initial begin
        int n;
        rst       = 2'b11;
        cmd_valid = 2'b00;
        cmd_duty[0] = 10'd0;
        cmd_duty[1] = 10'd0;

        // ---------------- reset ----------------
        repeat (3) cyc();
        chk("rst_duty", 32'(duty_out[0]), 32'd75);
        chk("rst_ready", 32'(cmd_ready[0]), 32'd0);
        chk("rst_moving", 32'(moving[0]), 32'd0);
        chk("rst_arrived", 32'(arrived[0]), 32'd0);
        chk("rst_clamped", 32'(clamped[0]), 32'd0);
        chk("rst_tick", 32'(frame_tick[0]), 32'd0);
        rst = 2'b00;
        cyc();
        chk("ready_after_release", 32'(cmd_ready[0]), 32'd1);
        chk("ready4_after_release", 32'(cmd_ready[1]), 32'd1);

        // frame_tick: one cycle wide, period 10
        pass_ft(0);
        chk("tick_width", 32'(frame_tick[0]), 32'd0);
        n = 0;
        while ((frame_tick[0] !== 1'b1) && (n < 25)) begin
            cyc();
            n++;
        end
        chk("tick_period", 32'(n), 32'd9);
        cyc();
        n = 0;
        while ((frame_tick[0] !== 1'b1) && (n < 25)) begin
            cyc();
            n++;
        end
        chk("tick_period2", 32'(n), 32'd9);

        // ---------------- ramp up, STEP = 1 ----------------
        send(0, 10'd100);
        chk("ramp_moving", 32'(moving[0]), 32'd1);
        chk("ramp_noclamp", 32'(clamped[0]), 32'd0);
        chk("ramp_hold", 32'(duty_out[0]), 32'd75);
        for (int i = 1; i <= 25; i++) begin
            tick_chk(0, 75 + i, (i == 25), "ramp");
        end
        cyc();
        chk("ramp_arrived_once", 32'(arrived[0]), 32'd0);

        // same-value command while idle at 100
        send(0, 10'd100);
        chk("same100_moving", 32'(moving[0]), 32'd0);
        chk("same100_arrived", 32'(arrived[0]), 32'd0);
        cyc();
        chk("same100_arrived2", 32'(arrived[0]), 32'd0);

        // ---------------- retarget mid-move ----------------
        do_reset(0);
        send(0, 10'd100);
        for (int i = 1; i <= 5; i++) begin
            tick_chk(0, 75 + i, 1'b0, "retgt_up");
        end
        send(0, 10'd60);
        chk("retgt_moving", 32'(moving[0]), 32'd1);
        chk("retgt_no_arrive80", 32'(arrived[0]), 32'd0);
        chk("retgt_hold80", 32'(duty_out[0]), 32'd80);
        for (int i = 1; i <= 20; i++) begin
            tick_chk(0, 80 - i, (i == 20), "retgt_dn");
        end

        // ---------------- accept coinciding with frame_tick ----------------
        do_reset(0);
        send(0, 10'd100);
        for (int i = 1; i <= 10; i++) begin
            tick_chk(0, 75 + i, 1'b0, "coin_up");
        end
        find_ft(0);
        cmd_valid[0] = 1'b1;
        cmd_duty[0]  = 10'd90;
        cyc();
        cmd_valid[0] = 1'b0;
        chk("coin_step_old_target", 32'(duty_out[0]), 32'd86);
        chk("coin_moving", 32'(moving[0]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick_chk(0, 86 + i, (i == 4), "coin");
        end

        // ---------------- reset during a ramp ----------------
        do_reset(0);
        send(0, 10'd100);
        for (int i = 1; i <= 13; i++) begin
            tick_chk(0, 75 + i, 1'b0, "mrst_up");
        end
        rst[0] = 1'b1;
        cyc();
        chk("mrst_duty", 32'(duty_out[0]), 32'd75);
        chk("mrst_moving", 32'(moving[0]), 32'd0);
        chk("mrst_ready", 32'(cmd_ready[0]), 32'd0);
        rst[0] = 1'b0;
        cyc();

        // ---------------- STEP = 4: same value, clamp low, clamp high -------
        send(1, 10'd75);
        chk("same75_moving", 32'(moving[1]), 32'd0);
        chk("same75_arrived", 32'(arrived[1]), 32'd0);
        chk("same75_clamped", 32'(clamped[1]), 32'd0);
        cyc();
        chk("same75_arrived2", 32'(arrived[1]), 32'd0);

        send(1, 10'd20);
        chk("clamp_lo_pulse", 32'(clamped[1]), 32'd1);
        chk("clamp_lo_moving", 32'(moving[1]), 32'd1);
        cyc();
        chk("clamp_lo_pulse_end", 32'(clamped[1]), 32'd0);
        tick_chk(1, 71, 1'b0, "step4");
        tick_chk(1, 67, 1'b0, "step4");
        tick_chk(1, 63, 1'b0, "step4");
        tick_chk(1, 59, 1'b0, "step4");
        tick_chk(1, 55, 1'b0, "step4");
        tick_chk(1, 51, 1'b0, "step4");
        tick_chk(1, 50, 1'b1, "step4_final");

        send(1, 10'd500);
        chk("clamp_hi_pulse", 32'(clamped[1]), 32'd1);
        tick_chk(1, 54, 1'b0, "clamp_hi_first");
        for (int i = 2; i <= 12; i++) begin
            tick_chk(1, 50 + 4 * i, 1'b0, "clamp_hi");
        end
        tick_chk(1, 100, 1'b1, "clamp_hi_final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/servo_slew_ctrl.md
# servo_slew_ctrl

Upstream command stage for the servo PWM generator. Accepts target pulse-width commands over a valid/ready handshake and clamps them to a safe servo range. It drives the generator's 10-bit `dutyCycle` input, ramping toward the target by at most `STEP` counts per PWM frame. `duty_out` changes only on frame boundaries, so the downstream PWM never sees a mid-period width change. With the 50 kHz system clock, 1 count = 20 us and 1 frame = 1000 clocks = 20 ms.

## Interface

- `FRAME_TICKS`, 1000: clocks per PWM frame. Must be ≥ 2 and ≤ 1024.
- `MIN_DUTY`, 50: lowest legal duty count (1.0 ms).
- `MAX_DUTY`, 100: highest legal duty count (2.0 ms).
- `INIT_DUTY`, 75: duty after reset (1.5 ms, centre). Must satisfy MIN_DUTY ≤ INIT_DUTY ≤ MAX_DUTY.
- `STEP`, 1: maximum duty change per frame. Must be ≥ 1.

- `clk`  in  1  system clock, 50 kHz.
- `rst`  in  1  synchronous, active-high reset. This block has one clock, and its reset is synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_duty`  in  10  requested duty count, unsigned.
- `cmd_ready`  out  1  block can accept a command.
- `duty_out`  out  10  duty count to the PWM generator.
- `moving`  out  1  high while `duty_out` ≠ target.
- `arrived`  out  1  one-cycle pulse when a move completes.
- `clamped`  out  1  one-cycle pulse when an accepted command was clamped.
- `frame_tick`  out  1  one-cycle pulse on the last clock of each frame.

## Operation

- **Frame counter:** `fcnt` counts 0 to FRAME_TICKS−1, then wraps to 0. `frame_tick` = (`fcnt` == FRAME_TICKS−1), decoded combinationally from the register.
- **Handshake:** a command is accepted on any rising edge where `cmd_valid` && `cmd_ready`. `cmd_ready` is a register: it is 0 in reset and 1 from the first edge after `rst` deasserts. Commands are accepted in every state.
- **Clamp:** the target is MIN_DUTY if `cmd_duty` < MIN_DUTY, MAX_DUTY if `cmd_duty` > MAX_DUTY, and `cmd_duty` otherwise. `clamped` pulses for one cycle following acceptance when the command was out of range.
- **States:** IDLE and MOVING.
  - **IDLE → MOVING:** on acceptance when the clamped target ≠ `duty_out`.
  - **Accept while IDLE with target equal to `duty_out`:** the state stays IDLE and no `arrived` pulse is generated.
  - **MOVING, on a `frame_tick` cycle:**
    - If `duty_out` < target: `duty_out` += min(STEP, target − `duty_out`).
    - If `duty_out` > target: `duty_out` −= min(STEP, `duty_out` − target).
    - The difference is computed in 11 bits, so there is no wrap.
  - **MOVING → IDLE:** on the edge where `duty_out` becomes equal to the target. `arrived` is registered high for the following cycle.
  - **Accept while MOVING:** the target is replaced and the state remains MOVING. Direction may reverse. If the new target equals the current `duty_out`, the state goes to IDLE and `arrived` pulses.
- **`moving`:** equals (state == MOVING).
- **Duty range:** `duty_out` never leaves [MIN_DUTY, MAX_DUTY].

## Timing

- **Reset values:**
  - `fcnt` = 0, `duty_out` = INIT_DUTY, target = INIT_DUTY, state = IDLE.
  - `cmd_ready` = 0, `moving` = 0, `arrived` = 0, `clamped` = 0.
  - `frame_tick` = 0 (it is 0 whenever `fcnt` = 0 in reset).
- **First tick:** the first `frame_tick` occurs FRAME_TICKS−1 cycles after the first post-reset edge. Ticks then repeat every FRAME_TICKS cycles.
- **Command latency:** a command accepted on edge N updates the target and `moving` at edge N. `clamped` is high during cycle N → N+1.
- **Duty update:** `duty_out` updates only on the edge that ends a `frame_tick` cycle. It is stable for a full frame in between.
- **Acceptance coinciding with a `frame_tick`:** the step on that edge uses the old target. The new target applies from the next tick.
- **Move duration:** a move of distance D completes ceil(D/STEP) ticks after acceptance, or fewer when another command arrives mid-move.
- **Reset during a move:** all registers return to their reset values on the next edge. `duty_out` = INIT_DUTY immediately, with no ramp.
- **Reset timing:** `rst` is sampled only on rising edges of `clk`.

## Test plan

- **Reset:** assert `rst` for 3 cycles → `duty_out` = 75, `cmd_ready` = 0, `moving` = 0. `cmd_ready` = 1 one cycle after release. `frame_tick` pulses every FRAME_TICKS cycles (bench uses FRAME_TICKS = 10).
- **Ramp up:** STEP = 1; command 100 → `moving` = 1; `duty_out` runs 76, 77, … 100 over 25 ticks, one per tick. `arrived` pulses once, then `moving` = 0.
- **Clamp and large step:** STEP = 4; command 20 → `clamped` pulse, target 50. `duty_out` sequence is 71, 67, … 51, 50; the final step is 1.
- **Retarget mid-move:** from 75, command 100; after 5 ticks (`duty_out` = 80) command 60 → direction reverses. `duty_out` runs 79 … 60, then `arrived` pulses. There is no `arrived` pulse at 80.
- **Coincident accept:** command 90 accepted on a `frame_tick` cycle while moving to 100 at `duty_out` = 85 → that edge gives 86. The following ticks run 87 … 90, then `arrived` pulses.
- **Same-value command and mid-move reset:**
  - Command 75 while IDLE → no `moving` and no `arrived`.
  - Reset asserted during a ramp at 88 → `duty_out` = 75 on the next edge and `moving` = 0.
